// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
// master = producer/consumer side (decode + writeback), slave = the ALU.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU (ADD SUB AND SLL SRL XOR OR SRA ROL, optional MUL).
// Optional iterative shift-add multiply (op 9) is enabled by defining SEQ_ALU_MUL_EN;
// without it op 9 decodes as illegal and the BUSY state/accumulator do not exist.
module seq_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic     CLK,
    input logic     Reset,
    seq_alu_if.slave bus
);
    localparam logic [OPW-1:0] OpAdd = OPW'(0);
    localparam logic [OPW-1:0] OpSub = OPW'(1);
    localparam logic [OPW-1:0] OpAnd = OPW'(2);
    localparam logic [OPW-1:0] OpSll = OPW'(3);
    localparam logic [OPW-1:0] OpSrl = OPW'(4);
    localparam logic [OPW-1:0] OpXor = OPW'(5);
    localparam logic [OPW-1:0] OpOr  = OPW'(6);
    localparam logic [OPW-1:0] OpSra = OPW'(7);
    localparam logic [OPW-1:0] OpRol = OPW'(8);

`ifdef SEQ_ALU_MUL_EN
    localparam logic [OPW-1:0] OpMul = OPW'(9);
    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;
`else
    typedef enum logic [0:0] {StIdle, StHold} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             illegal_q, illegal_d;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nxt;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic               is_mul;
`endif

    logic             accept;
    logic [SHW-1:0]   s;
    logic [SHW:0]     rot_amt;
    logic [WIDTH:0]   sum_ext, diff_ext, sll_ext, srl_ext, sra_ext;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;

    assign s        = bus.b[SHW-1:0];
    assign rot_amt  = (SHW + 1)'(WIDTH) - {1'b0, s};
    assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
    // Extra bit beyond the data catches the last bit shifted out (stays 0 when s == 0).
    assign sll_ext  = {1'b0, bus.a} << s;
    assign srl_ext  = {bus.a, 1'b0} >> s;
    assign sra_ext  = $unsigned($signed({bus.a, 1'b0}) >>> s);
    assign rol_res  = (bus.a << s) | (bus.a >> rot_amt);

    assign accept   = bus.in_valid && bus.in_ready;
`ifdef SEQ_ALU_MUL_EN
    assign is_mul   = (bus.op == OpMul);
    assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    // Single-cycle operation decode: result, carry, overflow, illegal.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (bus.op)
            OpAdd: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = ~diff_ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpAnd: alu_res = bus.a & bus.b;
            OpOr:  alu_res = bus.a | bus.b;
            OpXor: alu_res = bus.a ^ bus.b;
            OpSll: begin
                alu_res = sll_ext[WIDTH-1:0];
                alu_c   = sll_ext[WIDTH];
            end
            OpSrl: begin
                alu_res = srl_ext[WIDTH:1];
                alu_c   = srl_ext[0];
            end
            OpSra: begin
                alu_res = sra_ext[WIDTH:1];
                alu_c   = sra_ext[0];
            end
            OpRol: begin
                alu_res = rol_res;
                alu_c   = rol_res[0];
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // Input readiness: always in IDLE, follows out_ready in HOLD, never while multiplying.
    always_comb begin
        bus.in_ready = 1'b0;
        case (state_q)
            StIdle:  bus.in_ready = 1'b1;
            StHold:  bus.in_ready = bus.out_ready;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign bus.out_valid = (state_q == StHold);
    assign bus.result    = result_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.illegal   = illegal_q;

    // Next-state logic: capture on accept, iterate MUL in BUSY, release HOLD on out_ready.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        illegal_d = illegal_q;
`ifdef SEQ_ALU_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            StIdle, StHold: begin
                if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                    if (is_mul) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        cnt_d    = (SHW + 1)'(WIDTH);
                        state_d  = StBusy;
                    end else
`endif
                    begin
                        result_d  = alu_res;
                        z_d       = (alu_res == '0);
                        n_d       = alu_res[WIDTH-1];
                        c_d       = alu_c;
                        v_d       = alu_v;
                        illegal_d = alu_ill;
                        state_d   = StHold;
                    end
                end else if ((state_q == StHold) && bus.out_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            StBusy: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                // Final iteration: product is complete in acc_nxt.
                if (cnt_q == (SHW + 1)'(1)) begin
                    result_d  = acc_nxt[WIDTH-1:0];
                    z_d       = (acc_nxt[WIDTH-1:0] == '0);
                    n_d       = acc_nxt[WIDTH-1];
                    c_d       = |acc_nxt[2*WIDTH-1:WIDTH];
                    v_d       = |acc_nxt[2*WIDTH-1:WIDTH];
                    illegal_d = 1'b0;
                    state_d   = StHold;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            illegal_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            v_q       <= v_d;
            illegal_q <= illegal_d;
`ifdef SEQ_ALU_MUL_EN
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=8).
// Observation vector: {out_valid, in_ready, result[7:0], z, n, c, v, illegal}.
module tb_seq_alu;
    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    seq_alu_if #(.WIDTH(8), .OPW(4)) bus ();

    seq_alu #(.WIDTH(8), .OPW(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [14:0] exp;
    } vec_t;

    function automatic logic [14:0] obs();
        return {bus.out_valid, bus.in_ready, bus.result, bus.flag_z, bus.flag_n,
                bus.flag_c, bus.flag_v, bus.illegal};
    endfunction

    // Expected observation while holding a result with out_ready=1.
    function automatic logic [14:0] hold(input logic [7:0] r, input logic [4:0] f);
        return {1'b1, 1'b1, r, f};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd0;
        bus.a         = 8'h11;
        bus.b         = 8'h22;
        bus.out_ready = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        Reset        = 1'b0;
        #1;
        checks++;
        if (obs() !== 15'b0_1_00000000_00000) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs(), 15'b0_1_00000000_00000);
        end
    endtask

    task automatic test_back_to_back();
        vec_t vecs[16];
        vecs[0]  = '{4'd0, 8'h7F, 8'h01, hold(8'h80, 5'b01010)};
        vecs[1]  = '{4'd1, 8'h05, 8'h05, hold(8'h00, 5'b10100)};
        vecs[2]  = '{4'd0, 8'hFF, 8'h01, hold(8'h00, 5'b10100)};
        vecs[3]  = '{4'd1, 8'h00, 8'h01, hold(8'hFF, 5'b01000)};
        vecs[4]  = '{4'd1, 8'h80, 8'h01, hold(8'h7F, 5'b00110)};
        vecs[5]  = '{4'd2, 8'hF0, 8'h3C, hold(8'h30, 5'b00000)};
        vecs[6]  = '{4'd6, 8'hF0, 8'h0F, hold(8'hFF, 5'b01000)};
        vecs[7]  = '{4'd5, 8'hAA, 8'hAA, hold(8'h00, 5'b10000)};
        vecs[8]  = '{4'd3, 8'h81, 8'h01, hold(8'h02, 5'b00100)};
        vecs[9]  = '{4'd4, 8'h81, 8'h01, hold(8'h40, 5'b00100)};
        vecs[10] = '{4'd7, 8'h90, 8'h03, hold(8'hF2, 5'b01000)};
        vecs[11] = '{4'd8, 8'h81, 8'h01, hold(8'h03, 5'b00100)};
        vecs[12] = '{4'd3, 8'h01, 8'h08, hold(8'h01, 5'b00000)};
        vecs[13] = '{4'd12, 8'h55, 8'hAA, hold(8'h00, 5'b10001)};
        vecs[14] = '{4'd7, 8'h80, 8'h07, hold(8'hFF, 5'b01000)};
        vecs[15] = '{4'd8, 8'h96, 8'h03, hold(8'hB4, 5'b01000)};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.op = vecs[i].op;
            bus.a  = vecs[i].a;
            bus.b  = vecs[i].b;
            step();
            checks++;
            if (obs() !== vecs[i].exp) begin
                failures++;
                $display("FAIL alu_vec%0d op=%0d a=%h b=%h got=%h want=%h",
                         i, vecs[i].op, vecs[i].a, vecs[i].b, obs(), vecs[i].exp);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_to_idle got=%b want=01", {bus.out_valid, bus.in_ready});
        end
    endtask

    task automatic test_mul();
        vec_t vecs[4];
`ifdef SEQ_ALU_MUL_EN
        vecs[0] = '{4'd9, 8'h10, 8'h11, hold(8'h10, 5'b00110)};
        vecs[1] = '{4'd9, 8'hFF, 8'hFF, hold(8'h01, 5'b00110)};
        vecs[2] = '{4'd9, 8'h03, 8'h05, hold(8'h0F, 5'b00000)};
        vecs[3] = '{4'd9, 8'h0C, 8'h0B, hold(8'h84, 5'b01000)};
`else
        vecs[0] = '{4'd9, 8'h10, 8'h11, hold(8'h00, 5'b10001)};
        vecs[1] = '{4'd9, 8'hFF, 8'hFF, hold(8'h00, 5'b10001)};
        vecs[2] = '{4'd9, 8'h03, 8'h05, hold(8'h00, 5'b10001)};
        vecs[3] = '{4'd9, 8'h0C, 8'h0B, hold(8'h00, 5'b10001)};
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = vecs[i].op;
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            step();
            bus.in_valid = 1'b0;
`ifdef SEQ_ALU_MUL_EN
            for (int k = 0; k < 8; k++) begin
                #1;
                checks++;
                if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
                    failures++;
                    $display("FAIL mul%0d_busy_cyc%0d got=%b want=00",
                             i, k + 1, {bus.out_valid, bus.in_ready});
                end
                step();
            end
`endif
            checks++;
            if (obs() !== vecs[i].exp) begin
                failures++;
                $display("FAIL mul%0d a=%h b=%h got=%h want=%h",
                         i, vecs[i].a, vecs[i].b, obs(), vecs[i].exp);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd0;
        bus.a         = 8'h02;
        bus.b         = 8'h03;
        step();
        bus.out_ready = 1'b0;
        bus.op        = 4'd5;
        bus.a         = 8'hFF;
        bus.b         = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (obs() !== 15'b1_0_00000101_00000) begin
                failures++;
                $display("FAIL backpressure_cyc%0d got=%h want=%h",
                         k, obs(), 15'b1_0_00000101_00000);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== hold(8'hF0, 5'b01000)) begin
            failures++;
            $display("FAIL bp_new_capture got=%h want=%h", obs(), hold(8'hF0, 5'b01000));
        end
        step();
        checks++;
        if (obs() !== 15'b0_1_11110000_01000) begin
            failures++;
            $display("FAIL bp_idle got=%h want=%h", obs(), 15'b0_1_11110000_01000);
        end
    endtask

    task automatic test_reset_mid_op();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd9;
        bus.a         = 8'h10;
        bus.b         = 8'h11;
        step();
        bus.in_valid = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        // Now in BUSY cycle 1; advance to cycle 4.
        step();
        step();
        step();
`else
        bus.out_ready = 1'b0;
`endif
        Reset = 1'b1;
        step();
        Reset         = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== 15'b0_1_00000000_00000) begin
            failures++;
            $display("FAIL reset_mid_op got=%h want=%h", obs(), 15'b0_1_00000000_00000);
        end
        bus.in_valid = 1'b1;
        bus.op       = 4'd0;
        bus.a        = 8'h02;
        bus.b        = 8'h03;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== hold(8'h05, 5'b00000)) begin
            failures++;
            $display("FAIL add_after_reset got=%h want=%h", obs(), hold(8'h05, 5'b00000));
        end
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        Reset         = 1'b1;
        test_reset();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised successor to the fixed 3-bit-opcode ALU definitions: a registered, handshaked ALU with width set by parameter.
- Adds OR, SRA, ROL and an iterative shift-add multiply.
- Sits between the decode stage and writeback. Operands are accepted on a valid/ready handshake; the result and flags are held in an output register until consumed.
- Opcodes 0-5 keep the existing encodings: ADD=0, SUB=1, AND=2, SLL=3, SRL=4, XOR=5.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- OPW, 4, opcode width; opcodes >= 2**3 need OPW >= 4.
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].

Ports:
- CLK  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  OPW  opcode: 0 ADD, 1 SUB, 2 AND, 3 SLL, 4 SRL, 5 XOR, 6 OR, 7 SRA, 8 ROL, 9 MUL, 10-15 illegal.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (shift/rotate amount in B[SHW-1:0]).
- out_valid  out  1  result register valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry (definition per op below).
- flag_v  out  1  signed overflow.
- illegal  out  1  opcode was unsupported.

Behaviour:
- Reset (synchronous, Reset=1 at CLK edge):
  - state=IDLE.
  - out_valid, result, all flags, illegal = 0.
  - Multiply accumulator/counter = 0.
  - Reset overrides any in-flight MUL and any held result.
- State machine IDLE / BUSY / HOLD:
  - IDLE: in_ready=1. On in_valid, capture the operation.
    - Single-cycle op: compute, load the output register, go to HOLD. out_valid rises the next cycle (latency 1).
    - MUL: load multiplicand, multiplier and counter=WIDTH; go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle: if the multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH accumulator; shift; decrement the counter. When the counter reaches 1, load the output register and go to HOLD. Latency from accept to out_valid = WIDTH+1 cycles.
  - HOLD: out_valid=1; result and flags are stable until the handshake completes.
    - in_ready = out_ready (combinational), so back-to-back ops are possible.
    - out_ready=1 with in_valid=1: accept the new op in the same cycle (single-cycle op stays in HOLD with new contents; MUL goes to BUSY).
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=0: stay in HOLD and ignore in_valid.
- Arithmetic (all WIDTH-bit, wrap-around):
  - ADD: c = carry out; v = signed overflow.
  - SUB: a-b; c = 1 when a>=b unsigned (no borrow); v = signed overflow.
  - AND/OR/XOR: c=0, v=0.
  - SLL/SRL: shift by s=B[SHW-1:0], zero fill; c = last bit shifted out, 0 when s=0; v=0.
  - SRA: sign fill; c as for SRL; v=0.
  - ROL: rotate left by s; c = result[0]; v=0.
  - MUL: unsigned; result = low WIDTH bits; c = v = (high WIDTH bits != 0).
  - Illegal opcode: single cycle, result=0, z=1, illegal=1, other flags 0.
  - z and n are always derived from the final result.
- in_valid while in_ready=0: not accepted. The source must hold its values; no error is raised.

Optional Feature:
- Macro: SEQ_ALU_MUL_EN.
- Defined: MUL (op 9) is implemented as above; the BUSY state and accumulator exist.
- Undefined: BUSY logic and accumulator are removed. Op 9 is treated as an illegal opcode (1-cycle latency, result=0, illegal=1).

Test Plan (WIDTH=8):
- Reset held 2 cycles, then released -> out_valid=0, result=0x00, all flags 0, in_ready=1.
- ADD a=0x7F b=0x01, out_ready=1 -> next cycle result=0x80, n=1, v=1, c=0, z=0. SUB a=0x05 b=0x05 -> result=0x00, z=1, c=1.
- SRA a=0x90 b=0x03 -> result=0xF2, c=0. ROL a=0x81 b=0x01 -> result=0x03, c=1. SLL a=0x01 b=0x08 (s=0) -> result=0x01, c=0.
- MUL a=0x10 b=0x11 with SEQ_ALU_MUL_EN -> in_ready=0 for 8 cycles; out_valid 9 cycles after accept; result=0x10, c=v=1. Without the macro -> 1 cycle later, result=0x00, illegal=1.
- Backpressure: single-cycle op completes, out_ready=0 for 3 cycles with in_valid=1 -> result stable, in_ready=0, no new capture; out_ready=1 -> new op captured the same cycle.
- Reset asserted mid-MUL (cycle 4 of BUSY) -> next cycle state IDLE, out_valid=0, in_ready=1; a following ADD 0x02+0x03 gives 0x05.
